// File: rtl/cfg_afu_cap_loader_if.sv
// cfg_afu_cap_loader_if: load-word stream from the flash/VPD sequencer into the capability loader.
interface cfg_afu_cap_loader_if;
    logic        ld_valid;
    logic        ld_ready;
    logic        ld_glob;
    logic [4:0]  ld_afu;
    logic [2:0]  ld_field;
    logic [31:0] ld_data;
    logic        ld_last;

    modport master (
        output ld_valid, ld_glob, ld_afu, ld_field, ld_data, ld_last,
        input  ld_ready
    );

    modport slave (
        input  ld_valid, ld_glob, ld_afu, ld_field, ld_data, ld_last,
        output ld_ready
    );
endinterface

// File: rtl/cfg_afu_cap_loader.sv
// cfg_afu_cap_loader: function-1 read-only capability fields for NUM_AFU AFUs.
// Defaults come from parameters; a post-reset load stream may override them into a shadow
// copy, which is validated and then committed atomically to the active copy driving outputs.
// Optional feature macro: CFG_AFU_CAP_RELOAD_EN (adds reload_req to restart loading from DONE).
module cfg_afu_cap_loader #(
    parameter int unsigned NUM_AFU        = 1,
    parameter logic [63:0] BAR0_SIZE_DEF  = 64'hFFFF_FFFF_FC00_0000,
    parameter logic [4:0]  PASID_W_DEF    = 5'd9,
    parameter logic [11:0] ACTAG_LEN_DEF  = 12'h020,
    parameter logic [7:0]  RST_DUR_DEF    = 8'h10,
    parameter logic [15:0] SUBSYS_ID_DEF  = 16'h066B,
    parameter logic [15:0] SUBSYS_VID_DEF = 16'h1014,
    parameter int unsigned LOAD_TIMEOUT   = 4096
) (
    input  logic                     clock,
    input  logic                     reset_n,
    cfg_afu_cap_loader_if.slave      ld,
`ifdef CFG_AFU_CAP_RELOAD_EN
    input  logic                     reload_req,
`endif
    output logic                     cfg_ready,
    output logic                     load_err,
    output logic                     load_timeout,
    output logic                     bad_addr,
    output logic [63:0]              f1_ro_csh_mmio_bar0_size,
    output logic [15:0]              f1_ro_csh_subsystem_id,
    output logic [15:0]              f1_ro_csh_subsystem_vendor_id,
    output logic [4:0]               f1_ro_pasid_max_pasid_width,
    output logic [4:0]               f1_ro_ofunc_max_afu_index,
    output logic [NUM_AFU*8-1:0]     f1_ro_octrl_reset_duration,
    output logic [NUM_AFU*5-1:0]     f1_ro_octrl_pasid_len_supported,
    output logic [NUM_AFU*12-1:0]    f1_ro_octrl_actag_len_supported,
    output logic [NUM_AFU*6-1:0]     f1_ro_octrl_afu_control_index
);
    localparam int unsigned IDX_W = (NUM_AFU > 1) ? $clog2(NUM_AFU) : 1;
    localparam int unsigned CNT_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;

    typedef enum logic [1:0] {ST_LOAD, ST_CHECK, ST_COMMIT, ST_DONE} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_ld_ready;
    logic               r_cfg_ready;
    logic               r_load_err;
    logic               r_load_timeout;
    logic               r_bad_addr;
    logic               r_fail;

    logic [63:0]        r_sh_bar0,  r_act_bar0;
    logic [15:0]        r_sh_sid,   r_act_sid;
    logic [15:0]        r_sh_vid,   r_act_vid;
    logic [4:0]         r_sh_pmax,  r_act_pmax;
    logic [11:0]        r_sh_actag [NUM_AFU];
    logic [11:0]        r_act_actag[NUM_AFU];
    logic [4:0]         r_sh_plen  [NUM_AFU];
    logic [4:0]         r_act_plen [NUM_AFU];
    logic [7:0]         r_sh_rdur  [NUM_AFU];
    logic [7:0]         r_act_rdur [NUM_AFU];

    logic               w_xfer;
    logic               w_glob_hit;
    logic               w_afu_hit;
    logic               w_timeout;
    logic [63:0]        w_bar0_inv;
    logic               w_glob_bad;
    logic               w_afu_bad;
    logic [IDX_W-1:0]   w_ld_idx;

    // Handshake decode and field address classification
    assign w_xfer     = ld.ld_valid & r_ld_ready;
    assign w_glob_hit = ld.ld_glob & (ld.ld_field <= 3'd3);
    assign w_afu_hit  = ~ld.ld_glob & (ld.ld_field == 3'd0) & ({1'b0, ld.ld_afu} < 6'(NUM_AFU));
    assign w_ld_idx   = ld.ld_afu[IDX_W-1:0];
    assign w_timeout  = (r_cnt == CNT_W'(LOAD_TIMEOUT - 1));

    // Validation: bar0 mask must be ones-then-zeros, i.e. its inverse is a low run of ones
    assign w_bar0_inv = ~r_sh_bar0;
    assign w_glob_bad = ((w_bar0_inv & (w_bar0_inv + 64'd1)) != 64'd0) ||
                        (r_sh_bar0[19:0] != 20'd0) || (r_sh_pmax > 5'd20);
    assign w_afu_bad  = (r_sh_actag[r_idx] == 12'd0) || (r_sh_plen[r_idx] > r_sh_pmax);

    // Load / check / commit sequencer with shadow and active capability copies
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_LOAD;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_ld_ready     <= 1'b0;
            r_cfg_ready    <= 1'b0;
            r_load_err     <= 1'b0;
            r_load_timeout <= 1'b0;
            r_bad_addr     <= 1'b0;
            r_fail         <= 1'b0;
            r_sh_bar0      <= BAR0_SIZE_DEF;
            r_act_bar0     <= BAR0_SIZE_DEF;
            r_sh_sid       <= SUBSYS_ID_DEF;
            r_act_sid      <= SUBSYS_ID_DEF;
            r_sh_vid       <= SUBSYS_VID_DEF;
            r_act_vid      <= SUBSYS_VID_DEF;
            r_sh_pmax      <= PASID_W_DEF;
            r_act_pmax     <= PASID_W_DEF;
            for (int i = 0; i < int'(NUM_AFU); i++) begin
                r_sh_actag[i]  <= ACTAG_LEN_DEF;
                r_act_actag[i] <= ACTAG_LEN_DEF;
                r_sh_plen[i]   <= PASID_W_DEF;
                r_act_plen[i]  <= PASID_W_DEF;
                r_sh_rdur[i]   <= RST_DUR_DEF;
                r_act_rdur[i]  <= RST_DUR_DEF;
            end
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_xfer) begin
                        if (w_glob_hit) begin
                            case (ld.ld_field)
                                3'd0:    r_sh_bar0[31:0]  <= ld.ld_data;
                                3'd1:    r_sh_bar0[63:32] <= ld.ld_data;
                                3'd2:    begin
                                    r_sh_vid <= ld.ld_data[31:16];
                                    r_sh_sid <= ld.ld_data[15:0];
                                end
                                default: r_sh_pmax <= ld.ld_data[4:0];
                            endcase
                        end else if (w_afu_hit) begin
                            r_sh_actag[w_ld_idx] <= ld.ld_data[11:0];
                            r_sh_plen[w_ld_idx]  <= ld.ld_data[16:12];
                            r_sh_rdur[w_ld_idx]  <= ld.ld_data[24:17];
                        end else begin
                            r_bad_addr <= 1'b1;
                        end
                    end
                    // A final word arriving on the timeout cycle takes priority
                    if (w_xfer && ld.ld_last) begin
                        r_state    <= ST_CHECK;
                        r_ld_ready <= 1'b0;
                        r_idx      <= '0;
                        r_fail     <= 1'b0;
                    end else if (w_timeout) begin
                        r_state        <= ST_DONE;
                        r_ld_ready     <= 1'b0;
                        r_load_timeout <= 1'b1;
                    end else begin
                        r_ld_ready <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (w_glob_bad || w_afu_bad) begin
                        r_fail <= 1'b1;
                    end
                    if (r_idx == IDX_W'(NUM_AFU - 1)) begin
                        r_state <= ST_COMMIT;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_COMMIT: begin
                    if (r_fail) begin
                        r_load_err <= 1'b1;
                    end else begin
                        r_act_bar0  <= r_sh_bar0;
                        r_act_sid   <= r_sh_sid;
                        r_act_vid   <= r_sh_vid;
                        r_act_pmax  <= r_sh_pmax;
                        r_act_actag <= r_sh_actag;
                        r_act_plen  <= r_sh_plen;
                        r_act_rdur  <= r_sh_rdur;
                    end
                    r_state <= ST_DONE;
                end
                default: begin
                    r_cfg_ready <= 1'b1;
`ifdef CFG_AFU_CAP_RELOAD_EN
                    // Reload restarts from the committed values, not from parameter defaults
                    if (reload_req) begin
                        r_state        <= ST_LOAD;
                        r_cnt          <= '0;
                        r_ld_ready     <= 1'b1;
                        r_cfg_ready    <= 1'b0;
                        r_load_err     <= 1'b0;
                        r_load_timeout <= 1'b0;
                        r_bad_addr     <= 1'b0;
                        r_sh_bar0      <= r_act_bar0;
                        r_sh_sid       <= r_act_sid;
                        r_sh_vid       <= r_act_vid;
                        r_sh_pmax      <= r_act_pmax;
                        r_sh_actag     <= r_act_actag;
                        r_sh_plen      <= r_act_plen;
                        r_sh_rdur      <= r_act_rdur;
                    end
`endif
                end
            endcase
        end
    end

    // Outputs come from the active copy only
    assign ld.ld_ready                     = r_ld_ready;
    assign cfg_ready                       = r_cfg_ready;
    assign load_err                        = r_load_err;
    assign load_timeout                    = r_load_timeout;
    assign bad_addr                        = r_bad_addr;
    assign f1_ro_csh_mmio_bar0_size        = r_act_bar0;
    assign f1_ro_csh_subsystem_id          = r_act_sid;
    assign f1_ro_csh_subsystem_vendor_id   = r_act_vid;
    assign f1_ro_pasid_max_pasid_width     = r_act_pmax;
    assign f1_ro_ofunc_max_afu_index       = 5'(NUM_AFU - 1);

    // Per-AFU output packing, AFU i in slice i
    for (genvar g = 0; g < NUM_AFU; g++) begin : g_afu
        assign f1_ro_octrl_reset_duration[g*8 +: 8]       = r_act_rdur[g];
        assign f1_ro_octrl_pasid_len_supported[g*5 +: 5]  = r_act_plen[g];
        assign f1_ro_octrl_actag_len_supported[g*12 +: 12] = r_act_actag[g];
        assign f1_ro_octrl_afu_control_index[g*6 +: 6]    = 6'(g);
    end
endmodule

// File: tb/tb_cfg_afu_cap_loader.sv
// tb_cfg_afu_cap_loader: randomized and directed checks of the capability loader
// against a transaction-level model of shadow/active capability sets.
module tb_cfg_afu_cap_loader;
    localparam int unsigned NA  = 4;
    localparam int unsigned TMO = 64;

    typedef struct packed {
        logic [63:0]          bar0;
        logic [15:0]          sid;
        logic [15:0]          vid;
        logic [4:0]           pmax;
        logic [NA-1:0][7:0]   rdur;
        logic [NA-1:0][4:0]   plen;
        logic [NA-1:0][11:0]  actag;
    } cap_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cfg_afu_cap_loader_if ld_if();
`ifdef CFG_AFU_CAP_RELOAD_EN
    logic reload_req = 1'b0;
`endif
    logic              cfg_ready, load_err, load_timeout, bad_addr;
    logic [63:0]       bar0;
    logic [15:0]       sid, vid;
    logic [4:0]        pmax, max_idx;
    logic [NA*8-1:0]   rdur;
    logic [NA*5-1:0]   plen;
    logic [NA*12-1:0]  actag;
    logic [NA*6-1:0]   ctl_idx;

    cfg_afu_cap_loader #(.NUM_AFU(NA), .LOAD_TIMEOUT(TMO)) dut (
        .clock                            (clk),
        .reset_n                          (rst_n),
        .ld                               (ld_if),
`ifdef CFG_AFU_CAP_RELOAD_EN
        .reload_req                       (reload_req),
`endif
        .cfg_ready                        (cfg_ready),
        .load_err                         (load_err),
        .load_timeout                     (load_timeout),
        .bad_addr                         (bad_addr),
        .f1_ro_csh_mmio_bar0_size         (bar0),
        .f1_ro_csh_subsystem_id           (sid),
        .f1_ro_csh_subsystem_vendor_id    (vid),
        .f1_ro_pasid_max_pasid_width      (pmax),
        .f1_ro_ofunc_max_afu_index        (max_idx),
        .f1_ro_octrl_reset_duration       (rdur),
        .f1_ro_octrl_pasid_len_supported  (plen),
        .f1_ro_octrl_actag_len_supported  (actag),
        .f1_ro_octrl_afu_control_index    (ctl_idx)
    );

    int   checks = 0;
    int   errors = 0;
    cap_t m_act, m_sh, m_def;
    bit   m_bad;

    // ---------------- reference model ----------------
    function automatic void model_reset();
        m_def.bar0 = 64'hFFFF_FFFF_FC00_0000;
        m_def.sid  = 16'h066B;
        m_def.vid  = 16'h1014;
        m_def.pmax = 5'd9;
        for (int i = 0; i < int'(NA); i++) begin
            m_def.rdur[i]  = 8'h10;
            m_def.plen[i]  = 5'd9;
            m_def.actag[i] = 12'h020;
        end
        m_act = m_def;
        m_sh  = m_def;
        m_bad = 1'b0;
    endfunction

    function automatic void model_write(bit g, int afu, int f, logic [31:0] d);
        if (g && f == 0)      m_sh.bar0[31:0]  = d;
        else if (g && f == 1) m_sh.bar0[63:32] = d;
        else if (g && f == 2) begin m_sh.vid = d[31:16]; m_sh.sid = d[15:0]; end
        else if (g && f == 3) m_sh.pmax = d[4:0];
        else if (!g && f == 0 && afu < int'(NA)) begin
            m_sh.actag[afu] = d[11:0];
            m_sh.plen[afu]  = d[16:12];
            m_sh.rdur[afu]  = d[24:17];
        end else m_bad = 1'b1;
    endfunction

    function automatic bit model_ok(cap_t c);
        bit seen0 = 1'b0;
        bit ok = 1'b1;
        for (int b = 63; b >= 0; b--) begin
            if (!c.bar0[b]) seen0 = 1'b1;
            else if (seen0) ok = 1'b0;
        end
        if (c.bar0[19:0] != 20'd0) ok = 1'b0;
        if (c.pmax > 5'd20) ok = 1'b0;
        for (int i = 0; i < int'(NA); i++) begin
            if (c.actag[i] == 12'd0) ok = 1'b0;
            if (c.plen[i] > c.pmax) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic cap_t snap_dut();
        cap_t s;
        s.bar0 = bar0; s.sid = sid; s.vid = vid; s.pmax = pmax;
        s.rdur = rdur; s.plen = plen; s.actag = actag;
        return s;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        ld_if.ld_valid = 1'b0; ld_if.ld_glob = 1'b0; ld_if.ld_afu = '0;
        ld_if.ld_field = '0; ld_if.ld_data = '0; ld_if.ld_last = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic send(input bit g, input int afu, input int f, input logic [31:0] d, input bit last);
        int n = 0;
        ld_if.ld_valid = 1'b1; ld_if.ld_glob = g; ld_if.ld_afu = 5'(afu);
        ld_if.ld_field = 3'(f); ld_if.ld_data = d; ld_if.ld_last = last;
        while (ld_if.ld_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (ld_if.ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_handshake: ld_ready=%b after %0d cycles, want 1", ld_if.ld_ready, n);
        end else model_write(g, afu, f, d);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // Counts edges until cfg_ready and the first edge at which outputs moved
    task automatic run_to_done(output int lat, output int chg);
        cap_t s0;
        s0 = snap_dut();
        lat = -1; chg = -1;
        for (int k = 1; k <= 200 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (chg < 0 && snap_dut() !== s0) chg = k;
            if (cfg_ready === 1'b1) lat = k;
        end
    endtask

    task automatic finish_load(output int lat, output int chg, output int exp_chg, output bit exp_err);
        cap_t old;
        old = m_act;
        exp_err = !model_ok(m_sh);
        if (!exp_err) m_act = m_sh;
        exp_chg = (m_act != old) ? int'(NA) + 1 : -1;
        run_to_done(lat, chg);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [NA*6-1:0] exp_idx;
        rst_n = 1'b0; idle_inputs(); #1;
        repeat (2) @(posedge clk); #1;
        model_reset();
        for (int i = 0; i < int'(NA); i++) exp_idx[i*6 +: 6] = 6'(i);
        checks++;
        if ({cfg_ready, load_err, load_timeout, bad_addr, ld_if.ld_ready} !== 5'b0)
            begin errors++; $display("FAIL reset_flags: got %b want 00000", {cfg_ready, load_err, load_timeout, bad_addr, ld_if.ld_ready}); end
        checks++;
        if (snap_dut() !== m_act)
            begin errors++; $display("FAIL reset_defaults: got %h want %h", snap_dut(), m_act); end
        checks++;
        if (max_idx !== 5'(NA - 1) || ctl_idx !== exp_idx)
            begin errors++; $display("FAIL const_index: got %0d/%h want %0d/%h", max_idx, ctl_idx, NA - 1, exp_idx); end
        rst_n = 1'b1; #1;
        checks++;
        if (ld_if.ld_ready !== 1'b0)
            begin errors++; $display("FAIL ld_ready_first: got %b want 0", ld_if.ld_ready); end
        @(posedge clk); #1;
        checks++;
        if (ld_if.ld_ready !== 1'b1)
            begin errors++; $display("FAIL ld_ready_second: got %b want 1", ld_if.ld_ready); end
    endtask

    task automatic test_timeout();
        int lat, chg;
        do_reset();
        run_to_done(lat, chg);
        checks++;
        if (lat != int'(TMO) + 1)
            begin errors++; $display("FAIL timeout_latency: got %0d want %0d", lat, TMO + 1); end
        checks++;
        if ({load_timeout, load_err, bad_addr, ld_if.ld_ready} !== 4'b1000)
            begin errors++; $display("FAIL timeout_flags: got %b want 1000", {load_timeout, load_err, bad_addr, ld_if.ld_ready}); end
        checks++;
        if (snap_dut() !== m_act || bar0 !== 64'hFFFF_FFFF_FC00_0000)
            begin errors++; $display("FAIL timeout_values: got %h want %h", snap_dut(), m_act); end
    endtask

    task automatic test_afu_field();
        int lat, chg, exp_chg; bit exp_err;
        do_reset();
        send(1'b0, 2, 0, 32'h0022_1040, 1'b0);
        send(1'b1, 0, 3, 32'd9, 1'b1);
        finish_load(lat, chg, exp_chg, exp_err);
        checks++;
        if (lat != int'(NA) + 2 || chg != exp_chg)
            begin errors++; $display("FAIL afu_latency: got %0d/%0d want %0d/%0d", lat, chg, NA + 2, exp_chg); end
        checks++;
        if (snap_dut() !== m_act || actag[2*12 +: 12] !== 12'h040)
            begin errors++; $display("FAIL afu_values: got %h want %h", snap_dut(), m_act); end
        checks++;
        if ({load_err, bad_addr, load_timeout} !== {exp_err, m_bad, 1'b0})
            begin errors++; $display("FAIL afu_flags: got %b want %b", {load_err, bad_addr, load_timeout}, {exp_err, m_bad, 1'b0}); end
    endtask

    task automatic test_bad_bar0();
        int lat, chg, exp_chg; bit exp_err;
        do_reset();
        send(1'b1, 0, 0, 32'h0F00_0000, 1'b0);
        send(1'b1, 0, 1, 32'hFFFF_FFFF, 1'b1);
        finish_load(lat, chg, exp_chg, exp_err);
        checks++;
        if (load_err !== 1'b1 || exp_err !== 1'b1 || cfg_ready !== 1'b1)
            begin errors++; $display("FAIL bar0_err: got err=%b rdy=%b want err=1 rdy=1", load_err, cfg_ready); end
        checks++;
        if (snap_dut() !== m_act || chg != -1)
            begin errors++; $display("FAIL bar0_kept: got %h chg=%0d want %h chg=-1", snap_dut(), chg, m_act); end
    endtask

    task automatic test_bad_addr_done_hold();
        int lat, chg, exp_chg; bit exp_err; bit any_ready = 1'b0;
        cap_t held;
        do_reset();
        send(1'b0, 7, 0, 32'h0001_3055, 1'b0);
        send(1'b1, 0, 3, 32'd9, 1'b1);
        finish_load(lat, chg, exp_chg, exp_err);
        checks++;
        if ({bad_addr, load_err, cfg_ready} !== 3'b101 || m_bad !== 1'b1)
            begin errors++; $display("FAIL bad_addr_flags: got %b want 101", {bad_addr, load_err, cfg_ready}); end
        held = snap_dut();
        ld_if.ld_valid = 1'b1; ld_if.ld_glob = 1'b1; ld_if.ld_field = 3'd3;
        ld_if.ld_data = 32'd3; ld_if.ld_last = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (ld_if.ld_ready !== 1'b0) any_ready = 1'b1;
        end
        idle_inputs();
        checks++;
        if (any_ready || snap_dut() !== m_act || cfg_ready !== 1'b1)
            begin errors++; $display("FAIL done_hold: ready_seen=%b got %h want %h", any_ready, snap_dut(), m_act); end
    endtask

    task automatic test_last_on_timeout();
        int lat, chg, exp_chg; bit exp_err;
        do_reset();
        repeat (int'(TMO) - 1) @(posedge clk);
        #1;
        send(1'b1, 0, 3, 32'd12, 1'b1);
        checks++;
        if ({load_timeout, ld_if.ld_ready, cfg_ready} !== 3'b000)
            begin errors++; $display("FAIL last_wins: got %b want 000", {load_timeout, ld_if.ld_ready, cfg_ready}); end
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        checks++;
        if (snap_dut() !== m_def || {cfg_ready, load_timeout, ld_if.ld_ready} !== 3'b000)
            begin errors++; $display("FAIL reset_in_check: got %h rdy=%b want %h rdy=0", snap_dut(), cfg_ready, m_def); end
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        send(1'b0, 0, 0, {15'd0, 5'd10, 12'd1}, 1'b1);
        finish_load(lat, chg, exp_chg, exp_err);
        checks++;
        if (load_err !== exp_err || snap_dut() !== m_act)
            begin errors++; $display("FAIL shadow_reset: got err=%b %h want err=%b %h", load_err, snap_dut(), exp_err, m_act); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int lat, chg, exp_chg, nw, kind, afu, fld;
            bit exp_err, g;
            logic [63:0] mask;
            logic [31:0] d;
            do_reset();
            mask = ~64'd0 << $urandom_range(18, 40);
            if ($urandom_range(0, 3) == 0) mask = {$urandom, $urandom};
            nw = $urandom_range(1, 8);
            for (int w = 0; w < nw; w++) begin
                kind = $urandom_range(0, 9);
                g = 1'b1; afu = 0; fld = kind; d = $urandom;
                if (kind == 0) d = mask[31:0];
                else if (kind == 1) d = mask[63:32];
                else if (kind == 3) d = 32'($urandom_range(0, 22));
                else if (kind <= 7) begin
                    g = 1'b0; fld = 0; afu = $urandom_range(0, NA - 1);
                    d = {7'($urandom), 8'($urandom), 5'($urandom_range(0, 12)),
                         ($urandom_range(0, 5) == 0) ? 12'd0 : 12'($urandom_range(1, 4095))};
                end else if (kind == 8) begin
                    g = 1'b0; afu = $urandom_range(NA, 31); fld = 0;
                end else begin
                    g = 1'($urandom); afu = $urandom_range(0, NA - 1); fld = $urandom_range(4, 7);
                end
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                send(g, afu, fld, d, w == nw - 1);
            end
            finish_load(lat, chg, exp_chg, exp_err);
            checks++;
            if (lat != int'(NA) + 2 || chg != exp_chg)
                begin errors++; $display("FAIL rand%0d_timing: got %0d/%0d want %0d/%0d", it, lat, chg, NA + 2, exp_chg); end
            checks++;
            if (snap_dut() !== m_act)
                begin errors++; $display("FAIL rand%0d_values: got %h want %h", it, snap_dut(), m_act); end
            checks++;
            if ({load_err, bad_addr, load_timeout} !== {exp_err, m_bad, 1'b0})
                begin errors++; $display("FAIL rand%0d_flags: got %b want %b", it, {load_err, bad_addr, load_timeout}, {exp_err, m_bad, 1'b0}); end
        end
    endtask

`ifdef CFG_AFU_CAP_RELOAD_EN
    task automatic test_reload();
        int lat, chg, exp_chg; bit exp_err;
        do_reset();
        send(1'b0, 1, 0, {7'd0, 8'h33, 5'd4, 12'h101}, 1'b0);
        send(1'b0, 6, 0, 32'h1, 1'b1);
        finish_load(lat, chg, exp_chg, exp_err);
        reload_req = 1'b1;
        @(posedge clk); #1;
        reload_req = 1'b0;
        m_sh = m_act; m_bad = 1'b0;
        checks++;
        if ({cfg_ready, load_err, load_timeout, bad_addr, ld_if.ld_ready} !== 5'b00001)
            begin errors++; $display("FAIL reload_clear: got %b want 00001", {cfg_ready, load_err, load_timeout, bad_addr, ld_if.ld_ready}); end
        send(1'b0, 3, 0, {7'd0, 8'h44, 5'd7, 12'h0AB}, 1'b1);
        finish_load(lat, chg, exp_chg, exp_err);
        checks++;
        if (lat != int'(NA) + 2 || chg != exp_chg || snap_dut() !== m_act)
            begin errors++; $display("FAIL reload_commit: got %0d/%0d %h want %0d/%0d %h", lat, chg, snap_dut(), NA + 2, exp_chg, m_act); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_timeout();
        test_afu_field();
        test_bad_bar0();
        test_bad_addr_done_hold();
        test_last_on_timeout();
        test_random();
`ifdef CFG_AFU_CAP_RELOAD_EN
        test_reload();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
